// File: rtl/line_feeder_if.sv
// line_feeder_if: raw DE/VSYNC raster in, framed pixel stream out.
// master = video source / line-buffer side, slave = the framer.
interface line_feeder_if #(
    parameter int unsigned COLORDEPTH = 8
);
    localparam int unsigned POS_W = 11;

    // Raw raster from the video input
    logic [COLORDEPTH-1:0] vid_data_i;
    logic                  vid_de_i;
    logic                  vid_vs_i;

    // Framed stream towards the line buffer
    logic [COLORDEPTH-1:0] data_o;
    logic                  dv_o;
    logic                  line_end_o;
    logic                  frame_start_o;
    logic [POS_W-1:0]      x_o;
    logic [POS_W-1:0]      y_o;

    modport master (
        output vid_data_i, vid_de_i, vid_vs_i,
        input  data_o, dv_o, line_end_o, frame_start_o, x_o, y_o
    );

    modport slave (
        input  vid_data_i, vid_de_i, vid_vs_i,
        output data_o, dv_o, line_end_o, frame_start_o, x_o, y_o
    );
endinterface

// File: rtl/line_feeder.sv
// line_feeder: frames a DE/VSYNC raster into registered pixel/valid,
// a blanking line-end pulse and a frame-start pulse, with x/y position,
// truncation to SCREENWIDTH x SCREENHEIGHT and a sticky geometry flag.
// Optional feature: define LINE_FEEDER_LEN_CHECK_EN to build the width/height
// checks; otherwise len_err_o is tied low and err_clr_i is ignored.
module line_feeder #(
    parameter int unsigned COLORDEPTH   = 8,
    parameter int unsigned SCREENWIDTH  = 1600,
    parameter int unsigned SCREENHEIGHT = 900
) (
    input  logic         clk,
    input  logic         rst_n,
    line_feeder_if.slave lf,
    input  logic         err_clr_i,
    output logic         len_err_o
);
    localparam int unsigned    POS_W    = 11;
    localparam logic [POS_W-1:0] WIDTH_L  = POS_W'(SCREENWIDTH);
    localparam logic [POS_W-1:0] HEIGHT_L = POS_W'(SCREENHEIGHT);
    localparam logic [POS_W-1:0] POS_MAX  = '1;
    localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BLANK  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t                 state_q;
    logic                   de_q;
    logic                   vs_q;
    logic [POS_W-1:0]       x_cnt_q;
    logic [POS_W-1:0]       y_cnt_q;
    logic [POS_W-1:0]       x_cnt_d;
    logic [POS_W-1:0]       y_cnt_d;
    logic [COLORDEPTH-1:0]  data_q;
    logic                   dv_q;
    logic                   line_end_q;
    logic                   frame_start_q;
    logic [POS_W-1:0]       x_q;
    logic [POS_W-1:0]       y_q;

    logic                   vs_rise_c;
    logic                   de_fall_c;
    logic                   pix_in_range_c;

    // Edge detection against the previous-cycle copies of DE and VS
    assign vs_rise_c = lf.vid_vs_i & ~vs_q;
    assign de_fall_c = ~lf.vid_de_i & de_q;

    // A pixel is forwarded only inside the configured geometry
    assign pix_in_range_c = (x_cnt_q < WIDTH_L) && (y_cnt_q < HEIGHT_L);

    // Saturating position counters: x stops at the width, y at the counter max
    assign x_cnt_d = (x_cnt_q < WIDTH_L)  ? (x_cnt_q + POS_ONE) : x_cnt_q;
    assign y_cnt_d = (y_cnt_q != POS_MAX) ? (y_cnt_q + POS_ONE) : y_cnt_q;

    // Framing FSM with all stream outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            de_q          <= 1'b0;
            vs_q          <= 1'b0;
            x_cnt_q       <= '0;
            y_cnt_q       <= '0;
            data_q        <= '0;
            dv_q          <= 1'b0;
            line_end_q    <= 1'b0;
            frame_start_q <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
        end else begin
            de_q          <= lf.vid_de_i;
            vs_q          <= lf.vid_vs_i;
            dv_q          <= 1'b0;
            line_end_q    <= 1'b0;
            frame_start_q <= 1'b0;

            unique case (state_q)
                IDLE: begin
                    // DE is ignored until the first frame boundary
                    if (vs_rise_c) begin
                        state_q       <= BLANK;
                        frame_start_q <= 1'b1;
                        x_cnt_q       <= '0;
                        y_cnt_q       <= '0;
                    end
                end

                BLANK: begin
                    if (vs_rise_c) begin
                        frame_start_q <= 1'b1;
                        y_cnt_q       <= '0;
                    end else if (lf.vid_de_i) begin
                        state_q <= ACTIVE;
                        if (pix_in_range_c) begin
                            dv_q   <= 1'b1;
                            data_q <= lf.vid_data_i;
                            x_q    <= x_cnt_q;
                            y_q    <= y_cnt_q;
                        end
                        x_cnt_q <= x_cnt_d;
                    end
                end

                ACTIVE: begin
                    if (vs_rise_c) begin
                        // New frame mid-line: abort the line, restart rows
                        state_q       <= BLANK;
                        line_end_q    <= 1'b1;
                        frame_start_q <= 1'b1;
                        x_cnt_q       <= '0;
                        y_cnt_q       <= '0;
                    end else if (de_fall_c) begin
                        state_q    <= BLANK;
                        line_end_q <= 1'b1;
                        x_cnt_q    <= '0;
                        y_cnt_q    <= y_cnt_d;
                    end else if (lf.vid_de_i) begin
                        if (pix_in_range_c) begin
                            dv_q   <= 1'b1;
                            data_q <= lf.vid_data_i;
                            x_q    <= x_cnt_q;
                            y_q    <= y_cnt_q;
                        end
                        x_cnt_q <= x_cnt_d;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign lf.data_o        = data_q;
    assign lf.dv_o          = dv_q;
    assign lf.line_end_o    = line_end_q;
    assign lf.frame_start_o = frame_start_q;
    assign lf.x_o           = x_q;
    assign lf.y_o           = y_q;

`ifdef LINE_FEEDER_LEN_CHECK_EN
    logic from_idle_q;
    logic x_ovf_q;
    logic len_err_q;
    logic err_set_c;

    // Geometry violations seen this cycle
    always_comb begin
        err_set_c = 1'b0;
        unique case (state_q)
            BLANK: begin
                if (vs_rise_c) begin
                    // The very first frame after IDLE has no previous height
                    err_set_c = !from_idle_q && (y_cnt_q != HEIGHT_L);
                end else if (lf.vid_de_i) begin
                    err_set_c = (y_cnt_q >= HEIGHT_L);
                end
            end
            ACTIVE: begin
                if (vs_rise_c) begin
                    err_set_c = 1'b1;
                end else if (de_fall_c) begin
                    err_set_c = x_ovf_q || (x_cnt_q != WIDTH_L);
                end
            end
            default: begin
                err_set_c = 1'b0;
            end
        endcase
    end

    // Check bookkeeping and the sticky flag; a set beats a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            from_idle_q <= 1'b0;
            x_ovf_q     <= 1'b0;
            len_err_q   <= 1'b0;
        end else begin
            if (state_q == IDLE && vs_rise_c) begin
                from_idle_q <= 1'b1;
            end else if (state_q == BLANK && (vs_rise_c || lf.vid_de_i)) begin
                from_idle_q <= 1'b0;
            end

            // x saturates at the width, so remember pixels beyond it here
            if (state_q != ACTIVE) begin
                x_ovf_q <= 1'b0;
            end else if (lf.vid_de_i && !vs_rise_c && (x_cnt_q == WIDTH_L)) begin
                x_ovf_q <= 1'b1;
            end

            if (err_set_c) begin
                len_err_q <= 1'b1;
            end else if (err_clr_i) begin
                len_err_q <= 1'b0;
            end
        end
    end

    assign len_err_o = len_err_q;
`else
    logic unused_err_clr;

    // Without checks the flag never rises and the clear has no effect
    assign unused_err_clr = err_clr_i;
    assign len_err_o      = 1'b0;
`endif

endmodule

// File: tb/tb_line_feeder.sv
// tb_line_feeder: table of framing scenarios, hand-written corner sequences
// and randomized rasters, every cycle checked against a raster-level model.
module tb_line_feeder;
    localparam int unsigned CD = 8;
    localparam int unsigned SW = 16;
    localparam int unsigned SH = 3;
`ifdef LINE_FEEDER_LEN_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic err_clr;
    logic len_err;

    line_feeder_if #(.COLORDEPTH(CD)) lf ();

    line_feeder #(
        .COLORDEPTH  (CD),
        .SCREENWIDTH (SW),
        .SCREENHEIGHT(SH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .lf       (lf),
        .err_clr_i(err_clr),
        .len_err_o(len_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int lines;
        int len;
        int gap;
        int ab_line;
        int ab_px;
        int exp_dv;
        int exp_le;
        int exp_fs;
        bit exp_err;
    } scen_t;

    scen_t tbl[5];

    int n_vec = 0;
    int n_err = 0;
    int c_dv, c_le, c_fs;

    // Raster-level reference state
    bit       m_live, m_in, m_fresh, m_err, m_pde, m_pvs;
    int       m_line, m_pix;
    bit       e_dv, e_le, e_fs;
    logic [7:0] e_data;
    int       e_x, e_y;

    task automatic model_reset();
        m_live = 0; m_in = 0; m_fresh = 0; m_err = 0; m_pde = 0; m_pvs = 0;
        m_line = 0; m_pix = 0;
        e_dv = 0; e_le = 0; e_fs = 0; e_data = '0; e_x = 0; e_y = 0;
    endtask

    task automatic model_step(input bit de, input bit vs, input logic [7:0] d, input bit clr);
        bit vr, fall, set;
        vr   = vs && !m_pvs;
        fall = !de && m_pde;
        set  = 0;
        e_dv = 0; e_le = 0; e_fs = 0;
        if (!m_live) begin
            if (vr) begin
                m_live = 1; m_fresh = 1; m_line = 0; m_in = 0; e_fs = 1;
            end
        end else if (vr) begin
            e_fs = 1;
            if (m_in) begin
                e_le = 1; set = 1; m_in = 0;
            end else if (!m_fresh && m_line != SH) begin
                set = 1;
            end
            m_line = 0; m_fresh = 0;
        end else if (m_in && fall) begin
            e_le = 1;
            if (m_pix != SW) set = 1;
            m_line = (m_line < 2047) ? m_line + 1 : 2047;
            m_in = 0;
        end else if (de) begin
            if (!m_in) begin
                m_in = 1; m_pix = 0; m_fresh = 0;
                if (m_line >= SH) set = 1;
            end
            if (m_pix < SW && m_line < SH) begin
                e_dv = 1; e_data = d; e_x = m_pix; e_y = m_line;
            end
            m_pix++;
        end
        if (set) m_err = 1;
        else if (clr) m_err = 0;
        m_pde = de; m_pvs = vs;
    endtask

    task automatic check_out(input string tag);
        logic exp_err;
        exp_err = CHK ? m_err : 1'b0;
        n_vec++;
        if (lf.dv_o !== e_dv || lf.data_o !== e_data || lf.line_end_o !== e_le ||
            lf.frame_start_o !== e_fs || lf.x_o !== 11'(e_x) || lf.y_o !== 11'(e_y) ||
            len_err !== exp_err) begin
            n_err++;
            $display("FAIL %s t=%0t: got dv=%b data=%h le=%b fs=%b x=%0d y=%0d err=%b, want dv=%b data=%h le=%b fs=%b x=%0d y=%0d err=%b",
                     tag, $time, lf.dv_o, lf.data_o, lf.line_end_o, lf.frame_start_o,
                     lf.x_o, lf.y_o, len_err, e_dv, e_data, e_le, e_fs, e_x, e_y, exp_err);
        end
    endtask

    task automatic check_val(input string tag, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, got, want);
        end
    endtask

    // One clock: drive at the falling edge, model at the rising edge, compare at the next falling edge
    task automatic cycle(input bit de, input bit vs, input logic [7:0] d, input bit clr);
        lf.vid_de_i   = de;
        lf.vid_vs_i   = vs;
        lf.vid_data_i = d;
        err_clr       = clr;
        @(posedge clk);
        if (rst_n) model_step(de, vs, d, clr);
        else model_reset();
        @(negedge clk);
        if (lf.dv_o === 1'b1) c_dv++;
        if (lf.line_end_o === 1'b1) c_le++;
        if (lf.frame_start_o === 1'b1) c_fs++;
        check_out("cycle");
    endtask

    task automatic do_reset();
        lf.vid_de_i = 0; lf.vid_vs_i = 0; lf.vid_data_i = '0; err_clr = 0;
        rst_n = 0;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        check_out("reset");
        rst_n = 1;
    endtask

    task automatic clr_counts();
        c_dv = 0; c_le = 0; c_fs = 0;
    endtask

    task automatic vs_pulse(input int hi);
        for (int i = 0; i < hi; i++) cycle(0, 1, 8'h00, 0);
        cycle(0, 0, 8'h00, 0);
    endtask

    task automatic line(input int len, input int gap, input int ab);
        for (int p = 0; p < len; p++) begin
            if (p == ab) begin
                cycle(1, 1, 8'(p), 0);
                break;
            end
            cycle(1, 0, 8'(p), 0);
        end
        for (int g = 0; g < gap; g++) cycle(0, 0, 8'h00, 0);
    endtask

    task automatic run_scen(input int idx, input scen_t s);
        do_reset();
        cycle(0, 0, 8'h00, 0);
        clr_counts();
        vs_pulse(2);
        for (int b = 0; b < 3; b++) cycle(0, 0, 8'h00, 0);
        for (int l = 0; l < s.lines; l++) line(s.len, s.gap, (l == s.ab_line) ? s.ab_px : -1);
        vs_pulse(2);
        for (int b = 0; b < 2; b++) cycle(0, 0, 8'h00, 0);
        check_val($sformatf("scen%0d_dv", idx), c_dv, s.exp_dv);
        check_val($sformatf("scen%0d_le", idx), c_le, s.exp_le);
        check_val($sformatf("scen%0d_fs", idx), c_fs, s.exp_fs);
        check_val($sformatf("scen%0d_err", idx), int'(len_err), int'(CHK & s.exp_err));
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lens[7];
        // lines, len, gap, abort line, abort px, dv, le, fs, err
        tbl[0] = '{3, 16, 4, -1, -1, 48, 3, 2, 1'b0};
        tbl[1] = '{1, 20, 4, -1, -1, 16, 1, 2, 1'b1};
        tbl[2] = '{4, 16, 4, -1, -1, 48, 4, 2, 1'b1};
        tbl[3] = '{3, 16, 3,  1,  7, 39, 3, 3, 1'b1};
        tbl[4] = '{3, 15, 1, -1, -1, 45, 3, 2, 1'b1};
        lens   = '{16, 16, 16, 15, 17, 20, 3};

        rst_n = 0; err_clr = 0;
        lf.vid_de_i = 0; lf.vid_vs_i = 0; lf.vid_data_i = '0;
        model_reset();

        for (int i = 0; i < 5; i++) run_scen(i, tbl[i]);

        // Sticky flag clears on request after an overlong line
        run_scen(1, tbl[1]);
        cycle(0, 0, 8'h00, 1);
        check_val("err_clear", int'(len_err), 0);

        // DE before the first frame boundary is ignored
        do_reset();
        clr_counts();
        for (int l = 0; l < 3; l++) line(5, 2, -1);
        check_val("pre_vs_dv", c_dv, 0);
        check_val("pre_vs_le", c_le, 0);
        vs_pulse(1);
        line(16, 2, -1);
        check_val("post_vs_dv", c_dv, 16);

        // Asynchronous reset mid-line, then no stream until a new VS edge
        do_reset();
        vs_pulse(1);
        cycle(0, 0, 8'h00, 0);
        for (int p = 0; p < 5; p++) cycle(1, 0, 8'(8'hA0 + p), 0);
        lf.vid_de_i = 1; lf.vid_data_i = 8'hA5;
        #2;
        rst_n = 0;
        #1;
        model_reset();
        check_out("async_reset");
        cycle(1, 0, 8'hA6, 0);
        cycle(1, 0, 8'hA7, 0);
        rst_n = 1;
        clr_counts();
        for (int p = 0; p < 8; p++) cycle(1, 0, 8'(p), 0);
        cycle(0, 0, 8'h00, 0);
        check_val("post_rst_dv", c_dv, 0);
        vs_pulse(1);
        line(16, 2, -1);
        check_val("resume_dv", c_dv, 16);

        // Randomized rasters with occasional aborts, odd lengths and clears
        do_reset();
        for (int f = 0; f < 8; f++) begin
            int nl;
            vs_pulse(int'($urandom_range(1, 3)));
            for (int b = 0; b < int'($urandom_range(0, 3)); b++) cycle(0, 0, 8'h00, 0);
            nl = int'($urandom_range(2, 4));
            for (int l = 0; l < nl; l++) begin
                int len, ab, gap;
                len = lens[$urandom_range(0, 6)];
                ab  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, len - 1)) : -1;
                gap = int'($urandom_range(1, 4));
                for (int p = 0; p < len; p++) begin
                    bit clr;
                    clr = ($urandom_range(0, 15) == 0);
                    if (p == ab) begin
                        cycle(1, 1, 8'($urandom), clr);
                        break;
                    end
                    cycle(1, 0, 8'($urandom), clr);
                end
                for (int g = 0; g < gap; g++) cycle(0, 0, 8'h00, ($urandom_range(0, 15) == 0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
